// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender. A two-entry skid buffer (OREG + SREG) lets it accept one beat
// per cycle under backpressure, and in_ready depends only on registered state.
module imm_extend_pipe #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_neg
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t                   state_q, state_d;
   logic signed [OUT_W-1:0]  oreg_q, oreg_d;
   logic signed [OUT_W-1:0]  sreg_q, sreg_d;
   logic                     neg_q, neg_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic                     in_xfer, out_xfer;
   logic signed [OUT_W-1:0]  ext;

   function automatic logic signed [OUT_W-1:0] extend(input logic [IN_W-1:0] d,
                                                      input logic [1:0]      m);
      logic signed [OUT_W-1:0] sx;
      sx = $signed({{(OUT_W-IN_W){d[IN_W-1]}}, d});
      case (m)
         2'b00:   return $signed({{(OUT_W-IN_W){1'b0}}, d});
         2'b01:   return sx;
         2'b10:   return $signed({sx[OUT_W-2:0], 1'b0});
         default: return $signed({d, {(OUT_W-IN_W){1'b0}}});
      endcase
   endfunction

   assign ext      = extend(in_data, in_mode);
   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = out_valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         oreg_q      <= '0;
         sreg_q      <= '0;
         neg_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         oreg_q      <= oreg_d;
         sreg_q      <= sreg_d;
         neg_q       <= neg_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (in_xfer) state_d = ONE;
         ONE: begin
            if (in_xfer && !out_xfer)      state_d = TWO;
            else if (!in_xfer && out_xfer) state_d = EMPTY;
         end
         TWO:     if (out_xfer) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   // Datapath moves: fresh beat into OREG when it is (or is becoming) free, else park it in SREG.
   always_comb begin
      oreg_d      = oreg_q;
      sreg_d      = sreg_q;
      in_ready_d  = (state_d != TWO);
      out_valid_d = (state_d != EMPTY);
      case (state_q)
         EMPTY: if (in_xfer) oreg_d = ext;
         ONE: begin
            if (in_xfer && out_xfer) oreg_d = ext;
            else if (in_xfer)        sreg_d = ext;
         end
         TWO:     if (out_xfer) oreg_d = sreg_q;
         default: ;
      endcase
      neg_d = oreg_d[OUT_W-1];
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = oreg_q;
   assign out_neg   = neg_q;

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit with valid/ready handshake on both sides. It widens an `IN_W`-bit field to `OUT_W` bits in one of four modes: zero-extend, sign-extend, sign-extend-and-shift, or load-upper. It sits between instruction decode and the ALU operand mux. It replaces fixed-width combinational extenders, and a two-entry skid buffer sustains one transfer per cycle under downstream backpressure.

## Interface
- `IN_W`, default 4: input field width, legal range 2..`OUT_W`-1.
- `OUT_W`, default 16: output width, greater than `IN_W`.
- `clk`  in  1: rising-edge clock; the only clock.
- `rst_n`  in  1: reset, synchronous, active-low. Sampled on the `clk` rising edge.
- `in_valid`  in  1: `in_data` and `in_mode` are valid.
- `in_ready`  out  1: unit can accept a beat. Registered.
- `in_data`  in  `IN_W`: raw immediate field.
- `in_mode`  in  2: 00 zero-extend, 01 sign-extend, 10 sign-extend then shift left 1, 11 load-upper.
- `out_valid`  out  1: `out_data` and `out_neg` are valid.
- `out_ready`  in  1: consumer accepts the beat.
- `out_data`  out  `OUT_W`: extended result. Registered.
- `out_neg`  out  1: `out_data[OUT_W-1]`, registered alongside `out_data`.

## Operation
- Input transfer: `in_valid && in_ready` on a rising edge. Output transfer: `out_valid && out_ready` on a rising edge.
- Extension is computed combinationally from the input and captured at the input transfer. `s` = `in_data[IN_W-1]`.
  - Mode 00: {(`OUT_W-IN_W`){0}, `in_data`}.
  - Mode 01: {(`OUT_W-IN_W`){s}, `in_data`}.
  - Mode 10: the mode-01 result shifted left 1 with LSB 0. The MSB of the sign-extended value is discarded; no overflow flag.
  - Mode 11: {`in_data`, (`OUT_W-IN_W`){0}}.
- Storage: output register OREG (drives `out_*`) plus skid register SREG.
- States:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - ONE: OREG full, `out_valid`=1, `in_ready`=1.
  - TWO: OREG and SREG full, `out_valid`=1, `in_ready`=0.
- Transitions:
  - EMPTY: input transfer goes to ONE, loading OREG.
  - ONE, input transfer only: go to TWO, loading SREG.
  - ONE, output transfer only: go to EMPTY.
  - ONE, input and output transfer together: stay in ONE, loading OREG with the new beat.
  - TWO, output transfer: go to ONE, moving SREG into OREG. No input transfer is possible in TWO.
- Beats leave in acceptance order. No beat is dropped or duplicated.
- `out_data` and `out_neg` hold stable while `out_valid`=1 and `out_ready`=0.
- `in_data` and `in_mode` are ignored when `in_valid`=0. Mode is captured per beat.

## Timing
- Latency: a beat accepted at edge N is presented with `out_valid`=1 after edge N. It transfers at the first edge ≥ N+1 where `out_ready`=1.
- Throughput: one beat per cycle while `out_ready`=1.
- `in_ready` is a registered function of state only and never depends combinationally on `out_ready`.
- `rst_n`=0 at an edge forces the following, regardless of handshake inputs:
  - state EMPTY;
  - `out_valid`=0, `out_data`=0, `out_neg`=0;
  - `in_ready`=1;
  - SREG=0.
- Reset mid-operation discards all held beats. The first edge with `rst_n`=1 can accept a beat.
- Bubble: `in_valid`=0 with an output transfer in ONE gives `out_valid`=0 on the next cycle.

## Test plan
- Mode sweep, `IN_W`=4, `OUT_W`=16, `in_data`=4'hA, `out_ready`=1:
  - mode 00 → 16'h000A, `out_neg`=0;
  - mode 01 → 16'hFFFA, `out_neg`=1;
  - mode 10 → 16'hFFF4;
  - mode 11 → 16'hA000, `out_neg`=1.
  - Also `in_data`=4'h5, mode 01 → 16'h0005.
- Backpressure: stream 4'h1, 4'h2, 4'h3 in mode 00 with `out_ready`=0. After two accepts, `in_ready`=0 and OREG shows 16'h0001. Raise `out_ready`: outputs 0001, 0002, 0003 in order, with `in_ready` returning to 1 one cycle after the first output transfer.
- Full throughput: 16 consecutive beats 0..F in mode 01 with `out_ready`=1. `in_ready` stays 1 throughout, and the outputs 0000..0007, FFF8..FFFF appear on consecutive cycles one cycle after acceptance.
- Simultaneous transfer in ONE: accept 4'h7, then on the next edge present 4'h8 (mode 01) with `out_ready`=1. State stays ONE, 0007 transfers out, and OREG becomes FFF8.
- Reset mid-operation: fill to TWO, then assert `rst_n`=0 for one edge. After that edge `out_valid`=0, `out_data`=0, `in_ready`=1. The next beat 4'h9 in mode 00 emerges as 16'h0009 with no stale beats.
- Parameter corner, `IN_W`=15, `OUT_W`=16: `in_data`=15'h4000 gives mode 01 → 16'hC000, mode 10 → 16'h8000, mode 11 → 16'h8000.
